// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU:
// operation encodings and FSM state encoding.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_NOT = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_ASR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_BEQ = 3'b110;
    localparam logic [2:0] OP_BNE = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb_core.sv
// Combinational ALU core: single-cycle ops plus
// the one-bit shift step used by the sequencer.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_sel,
    input  logic [WIDTH-1:0] i_sh_in,
    input  logic             i_sh_left,
    output logic [WIDTH-1:0] o_f,
    output logic             o_ovf,
    output logic             o_br,
    output logic [WIDTH-1:0] o_sh_out,
    output logic             o_sh_ovf
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        o_f   = i_a;
        o_ovf = 1'b0;
        o_br  = 1'b0;
        unique case (i_sel)
            OP_ADD: begin
                o_f   = w_sum;
                o_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1])
                     && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_NOT: o_f = ~i_b;
            OP_AND: o_f = i_a & i_b;
            OP_OR:  o_f = i_a | i_b;
            // zero-amount shifts pass a straight through
            OP_ASR: o_f = i_a;
            OP_SHL: o_f = i_a;
            OP_BEQ: begin
                o_f  = w_diff;
                o_br = (i_a == i_b);
            end
            OP_BNE: begin
                o_f  = w_diff;
                o_br = (i_a != i_b);
            end
            default: o_f = i_a;
        endcase
    end

    assign o_sh_out = i_sh_left
                    ? {i_sh_in[WIDTH-2:0], 1'b0}
                    : {i_sh_in[WIDTH-1], i_sh_in[WIDTH-1:1]};
    assign o_sh_ovf = i_sh_left
                    & (i_sh_in[WIDTH-1] ^ i_sh_in[WIDTH-2]);

endmodule

// File: rtl/alu_seq.sv
// Registered, handshaked ALU with multi-cycle shifts;
// one operation in flight, result held until taken.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic             take_branch,
    output logic             zero
);

    state_t           r_state;
    state_t           w_next;
    logic             r_go;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_sel;
    logic [SHW-1:0]   r_cnt;
    logic [WIDTH-1:0] r_sh;
    logic             r_sh_ovf;
    logic [WIDTH-1:0] r_f;
    logic             r_ovf;
    logic             r_br;
    logic             r_zero;

    logic             w_acc;
    logic             w_is_sh;
    logic             w_left;
    logic [SHW-1:0]   w_k;
    logic             w_enter_done;
    logic [WIDTH-1:0] w_alu_f;
    logic             w_alu_ovf;
    logic             w_alu_br;
    logic [WIDTH-1:0] w_sh_out;
    logic             w_sh_ovf;

    assign w_acc   = in_valid && in_ready;
    assign w_left  = (r_sel == OP_SHL);
    assign w_is_sh = (r_sel == OP_ASR) || w_left;
    assign w_k     = r_b[SHW-1:0];

    alu_comb_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_sel    (r_sel),
        .i_sh_in  (r_sh),
        .i_sh_left(w_left),
        .o_f      (w_alu_f),
        .o_ovf    (w_alu_ovf),
        .o_br     (w_alu_br),
        .o_sh_out (w_sh_out),
        .o_sh_ovf (w_sh_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // r_go marks the cycle after accept, while operands sit in r_a/r_b
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (r_go)
                    w_next = (w_is_sh && (w_k != '0)) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (r_cnt == SHW'(1)) w_next = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !r_go;
        out_valid = (r_state == ST_DONE);
    end

    assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_sel    <= OP_ADD;
            r_cnt    <= '0;
            r_sh     <= '0;
            r_sh_ovf <= 1'b0;
            r_f      <= '0;
            r_ovf    <= 1'b0;
            r_br     <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            r_go <= w_acc;
            if (w_acc) begin
                r_a   <= a;
                r_b   <= b;
                r_sel <= sel;
            end
            if ((r_state == ST_IDLE) && r_go) begin
                r_sh     <= r_a;
                r_cnt    <= w_k;
                r_sh_ovf <= 1'b0;
            end
            if (r_state == ST_SHIFT) begin
                r_sh     <= w_sh_out;
                r_cnt    <= r_cnt - 1'b1;
                r_sh_ovf <= r_sh_ovf | w_sh_ovf;
            end
            if (w_enter_done) begin
                if (r_state == ST_SHIFT) begin
                    r_f    <= w_sh_out;
                    r_ovf  <= w_left & (r_sh_ovf | w_sh_ovf);
                    r_br   <= 1'b0;
                    r_zero <= (w_sh_out == '0);
                end else begin
                    r_f    <= w_alu_f;
                    r_ovf  <= w_alu_ovf;
                    r_br   <= w_alu_br;
                    r_zero <= (w_alu_f == '0);
                end
            end
        end
    end

    assign f           = r_f;
    assign ovf         = r_ovf;
    assign take_branch = r_br;
    assign zero        = r_zero;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered, handshaked successor to the team's 8-bit combinational ALU.
- Keeps the same 3-bit operation encoding and flag semantics.
- Adds valid/ready flow control on the input and output sides.
- Shifts become multi-cycle, variable-amount operations run by a small FSM. Sits between the operand/decode stage and writeback/branch logic.

Parameters:
- WIDTH, 8, operand/result width in bits (≥4, power of two).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from b.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operands/op present.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  WIDTH  signed operand A.
- b  in  WIDTH  signed operand B; for shifts, b[SHW-1:0] is the shift amount.
- sel  in  3  operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- ovf  out  1  signed overflow.
- take_branch  out  1  branch condition.
- zero  out  1  f == 0.

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - State returns to IDLE; any in-flight operation is discarded.
  - f=0, ovf=0, take_branch=0, zero=0, out_valid=0, in_ready=1 (after release).
- Accept: a transfer happens when in_valid && in_ready at a rising edge. a, b, sel are captured internally; later input changes have no effect.
- States: IDLE, SHIFT, DONE.
  - IDLE -> DONE on accept of a non-shift op, or a shift with amount 0.
  - IDLE -> SHIFT on accept of a shift with amount k > 0.
  - SHIFT: one bit position per cycle; count decrements each cycle; -> DONE in the cycle the count reaches 0.
  - DONE: out_valid=1. -> IDLE when out_ready=1. f and flags are held stable while out_ready=0.
- Latency from the accept edge N:
  - Non-shift ops: out_valid rises after edge N+1.
  - Shift by k: out_valid rises after edge N+1+k.
- Throughput: one operation in flight. in_ready=0 in SHIFT and DONE. No accept in the same cycle as result retire; the next accept is possible the cycle after returning to IDLE.
- Operations (two's complement, all results truncated to WIDTH):
  - 000 ADD: f=a+b; ovf = (a msb == b msb) && (f msb != a msb).
  - 001 NOT: f=~b.
  - 010 AND: f=a&b.
  - 011 OR: f=a|b.
  - 100 ASR: f = a arithmetically shifted right by k; sign is replicated each step; ovf=0.
  - 101 SHL: f = a shifted left by k; ovf is sticky, set if the msb changes on any step.
  - 110 BEQ: f=a-b; take_branch = (a==b).
  - 111 BNE: f=a-b; take_branch = (a!=b).
- Flag defaults: ovf=0 and take_branch=0 unless the op defines them. zero is computed from the final f for every op.
- Outputs update only on entry to DONE. The previous result stays visible, with out_valid=0, in IDLE and SHIFT.
- Every output has an assignment on every path; there are no latches.

Decomposition:
- Shared package alu_pkg holds:
  - the sel encodings as localparams: OP_ADD, OP_NOT, OP_AND, OP_OR, OP_ASR, OP_SHL, OP_BEQ, OP_BNE;
  - the FSM state encoding: ST_IDLE, ST_SHIFT, ST_DONE.
- One sub-module is natural: alu_comb_core.
  - Purely combinational.
  - Implements ops 000–011 and 110–111 plus the single-step shift primitive.
  - alu_seq wraps it with the FSM, counter and output registers.

Test Plan (WIDTH=8):
- ADD overflow: accept a=100, b=50, sel=000, out_ready=1 -> one cycle later out_valid=1, f=0x96, ovf=1, zero=0.
- ASR multi-cycle: a=0x90, b=3, sel=100 -> in_ready=0 for 4 cycles; out_valid after edge N+4; f=0xF2, ovf=0.
- SHL overflow + backpressure:
  - a=0x30, b=2, sel=101, out_ready=0 -> f=0xC0, ovf=1.
  - Result held for 5 cycles while out_ready=0; retired when out_ready=1; in_ready=1 on the next cycle.
- Branch ops:
  - BEQ a=b=-5 -> take_branch=1, f=0, zero=1.
  - BNE a=7, b=3 -> take_branch=1, f=4.
  - BEQ a=7, b=3 -> take_branch=0.
- Shift by zero: a=0x55, b=0, sel=100 -> DONE after 1 cycle, f=0x55.
- Reset mid-shift: assert rst_n=0 during SHIFT of a shift with amount 7 -> outputs clear immediately. After release: in_ready=1, out_valid=0, and a new ADD 1+1 returns f=2.
